nussinov_core: RTL and testbench
================================

// Module: nussinov_core
// PURPOSE
//  Nussinov RNA-folding dynamic-programming engine (PolyBench nussinov, N=64) over a 64x64 score table.
//  The table lives in an external word-addressed RAM (row-major, addr = i*N+j) reached through two
//  ce/we ports with one-cycle read latency. A host wrapper drives the ap_ctrl_hs handshake and bridges
//  the RAM ports to a bus.
//  - The nucleotide sequence is internal: seq[i] = (i+1)%4.
//  - match(a,b) = 1 when a+b == 3, else 0.
// PARAMETERS
//  N         64  table dimension (rows = cols)
//  ADDR_WID  12  RAM address width; N*N must be <= 2**ADDR_WID
//  DATA_WID  32  table element width, signed two's complement
// PORTS
//  ap_clk            in   1         single clock, rising edge
//  ap_rst_n          in   1         asynchronous, active-low reset
//  ap_start          in   1         level start request
//  ap_done           out  1         one-cycle pulse when the table is complete
//  ap_idle           out  1         high while in IDLE
//  ap_ready          out  1         equal to ap_done
//  table_r_address0  out  ADDR_WID  port-0 address
//  table_r_ce0       out  1         port-0 enable
//  table_r_we0       out  1         port-0 write enable (only with ce0)
//  table_r_d0        out  DATA_WID  port-0 write data
//  table_r_q0        in   DATA_WID  port-0 read data, valid the cycle after ce0 & ~we0
//  table_r_address1, table_r_ce1, table_r_we1, table_r_d1, table_r_q1   same as port 0, for port 1
// BEHAVIOUR
//  Reset (async, ap_rst_n=0):
//  - FSM -> IDLE; all ce/we/done/ready = 0; ap_idle = 1; address/data outputs = 0.
//  - Reset taken mid-run abandons the run immediately. No further RAM access occurs.
//  Algorithm, sequential: for i=N-1 downto 0, for j=i+1 to N-1:
//  - v = max(T[i][j], T[i][j-1], T[i+1][j]).
//  - v = max(v, T[i+1][j-1] + (i<j-1 ? match(seq[i],seq[j]) : 0)).
//  - for k=i+1 to j-1: v = max(v, T[i][k] + T[k+1][j]).
//  - Write T[i][j] = v.
//  - All max/add are signed DATA_WID; sums wrap modulo 2**DATA_WID.
//  FSM states:
//  - IDLE: ap_start=1 -> LD0, with i=N-2, j=N-1 (row N-1 is empty).
//  - LD0: port0 reads [i][j], port1 reads [i][j-1].
//  - LD1: port0 reads [i+1][j], port1 reads [i+1][j-1]. The q values for LD0 arrive this cycle.
//  - CMB: captures the LD1 data and forms v. If j==i+1, go to WR; otherwise k=i+1 and go to KRD.
//  - KRD: port0 reads [i][k], port1 reads [k+1][j].
//  - KACC: v = max(v, q0+q1). k++; if k<j go to KRD, else go to WR.
//  - WR: ce0=we0=1, d0=v; port1 idle.
//  - NXT: j++. If j==N, then i-- and j=i+1. If i<0, go to FIN; otherwise go to LD0.
//  - FIN: ap_done=ap_ready=1 for one cycle, then IDLE. ap_start still high restarts the run.
//  Memory rules:
//  - The diagonal T[i][i] is never written.
//  - Exactly N*(N-1)/2 = 2016 writes per run.
//  - Never read and write the same address in one cycle. Port 1 never writes.
//  - ce may be held low for arbitrary cycles only between accesses; the wrapper may stall ap_clk.
//    Logic is purely edge-driven, with no combinational path from q to ce/address.
// CONFIGURATION
//  NUSSINOV_CYCLE_CNT_EN defined:
//  - Adds output port cycle_count (32b).
//  - Cleared on the IDLE->LD0 transition, increments every ap_clk cycle while not IDLE, frozen in IDLE.
//  - Reset value 0.
//  NUSSINOV_CYCLE_CNT_EN undefined: no such port and no counter logic.
// STRUCTURE
//  Package nussinov_pkg holds:
//  - N, ADDR_WID, DATA_WID.
//  - FSM state enum.
//  - Functions seq_of(idx), match(a,b), smax(a,b), and addr_of(i,j).
//  Sub-module nussinov_cell_update: combinational 4-input signed max plus match add, used in CMB.
//  Loop counters and FSM stay in nussinov_core.
// TESTING
//  1. Zero-filled RAM, start:
//     - ap_done after completion with 2016 writes.
//     - T[62][63]=0; T[0][5]>=1 (seq 1+2 match); T[2][7]>=1.
//     - Full table equals the C golden model.
//  2. RAM preset T[10][20]=100, rest 0: every T[i][j] with i<=10, j>=20 ends >=100; cells outside that region match the model.
//  3. Read latency: model RAM returns q exactly one cycle after ce. No read ever shares a cycle with a write to the same address.
//  4. Assert ap_rst_n=0 mid-run: ce0/ce1/we0 drop asynchronously and ap_idle=1. A new start then yields the golden table from fresh RAM.
//  5. ap_start held high: a second run starts right after the ap_done pulse; ap_done lasts exactly 1 cycle per run.
//  6. Negative preset, T[*][*] = -5 off-diagonal: results match the signed golden model (signed max, no unsigned compare).

Source files
------------

// File: rtl/nussinov_pkg.sv
// nussinov_pkg: shared table sizes, FSM encoding and scoring helpers for the Nussinov engine.
// Optional build macro NUSSINOV_CYCLE_CNT_EN is consumed by nussinov_core, not here.
package nussinov_pkg;

  localparam int N        = 64;
  localparam int ADDR_WID = 12;
  localparam int DATA_WID = 32;
  localparam int IDX_WID  = 7;

  typedef logic [IDX_WID-1:0]         idx_t;
  typedef logic signed [DATA_WID-1:0] data_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD0,
    ST_LD1,
    ST_CMB,
    ST_KRD,
    ST_KACC,
    ST_WR,
    ST_NXT,
    ST_FIN
  } state_t;

  // Nucleotide code of position idx: (idx+1) mod 4.
  function automatic logic [1:0] seq_of(input idx_t idx);
    return 2'(idx + idx_t'(1));
  endfunction

  function automatic logic match(input logic [1:0] a, input logic [1:0] b);
    return ({1'b0, a} + {1'b0, b}) == 3'd3;
  endfunction

  function automatic data_t smax(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

  // Row-major word address; stride is the table dimension.
  function automatic logic [ADDR_WID-1:0] addr_of(input idx_t i, input idx_t j, input int stride);
    return ADDR_WID'(int'(i) * stride + int'(j));
  endfunction

endpackage

// File: rtl/nussinov_cell_update.sv
// nussinov_cell_update: initial cell value = signed max of the three neighbours and the
// diagonal neighbour plus the optional pairing bonus.
module nussinov_cell_update
  import nussinov_pkg::*;
(
  input  data_t t_ij,
  input  data_t t_ijm1,
  input  data_t t_ip1j,
  input  data_t t_ip1jm1,
  input  logic  bonus,
  output data_t v
);

  data_t diag;

  always_comb begin
    diag = t_ip1jm1 + (bonus ? data_t'(1) : data_t'(0));
    v    = smax(smax(t_ij, t_ijm1), smax(t_ip1j, diag));
  end

endmodule

// File: rtl/nussinov_core.sv
// nussinov_core: sequential Nussinov DP over an external RAM with two 1-cycle-latency ports.
// Define NUSSINOV_CYCLE_CNT_EN to add the cycle_count output.
module nussinov_core
  import nussinov_pkg::*;
#(
  parameter int TBL_N = N
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  output logic [ADDR_WID-1:0] table_r_address0,
  output logic                table_r_ce0,
  output logic                table_r_we0,
  output logic [DATA_WID-1:0] table_r_d0,
  input  logic [DATA_WID-1:0] table_r_q0,
  output logic [ADDR_WID-1:0] table_r_address1,
  output logic                table_r_ce1,
  output logic                table_r_we1,
  output logic [DATA_WID-1:0] table_r_d1,
  input  logic [DATA_WID-1:0] table_r_q1
`ifdef NUSSINOV_CYCLE_CNT_EN
  ,
  output logic [31:0]         cycle_count
`endif
);

  state_t state_q, state_d;
  idx_t   i_q, j_q, k_q;
  idx_t   ip1, jm1, kp1;
  logic   bonus;
  data_t  t_ij_q, t_ijm1_q, v_q;
  data_t  cell_v, ksum;

  assign ip1   = i_q + idx_t'(1);
  assign jm1   = j_q - idx_t'(1);
  assign kp1   = k_q + idx_t'(1);
  assign bonus = (j_q != ip1) && match(seq_of(i_q), seq_of(j_q));
  assign ksum  = data_t'(table_r_q0) + data_t'(table_r_q1);

  nussinov_cell_update u_cell (
    .t_ij     (t_ij_q),
    .t_ijm1   (t_ijm1_q),
    .t_ip1j   (data_t'(table_r_q0)),
    .t_ip1jm1 (data_t'(table_r_q1)),
    .bonus    (bonus),
    .v        (cell_v)
  );

  // Control: state and loop indices
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            i_q <= idx_t'(TBL_N - 2);
            j_q <= idx_t'(TBL_N - 1);
          end
        end
        ST_CMB:  k_q <= ip1;
        ST_KACC: k_q <= kp1;
        ST_NXT: begin
          // End of row: the next row starts right above the diagonal at column old i.
          if (j_q == idx_t'(TBL_N - 1)) begin
            i_q <= i_q - idx_t'(1);
            j_q <= i_q;
          end else begin
            j_q <= j_q + idx_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Data: captured reads and running maximum
  always_ff @(posedge ap_clk) begin
    case (state_q)
      ST_LD1: begin
        t_ij_q   <= data_t'(table_r_q0);
        t_ijm1_q <= data_t'(table_r_q1);
      end
      ST_CMB:  v_q <= cell_v;
      ST_KACC: v_q <= smax(v_q, ksum);
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    table_r_address0 = '0;
    table_r_ce0      = 1'b0;
    table_r_we0      = 1'b0;
    table_r_d0       = '0;
    table_r_address1 = '0;
    table_r_ce1      = 1'b0;
    table_r_we1      = 1'b0;
    table_r_d1       = '0;
    ap_done          = 1'b0;
    case (state_q)
      ST_IDLE: if (ap_start) state_d = ST_LD0;
      ST_LD0: begin
        table_r_ce0      = 1'b1;
        table_r_ce1      = 1'b1;
        table_r_address0 = addr_of(i_q, j_q, TBL_N);
        table_r_address1 = addr_of(i_q, jm1, TBL_N);
        state_d          = ST_LD1;
      end
      ST_LD1: begin
        table_r_ce0      = 1'b1;
        table_r_ce1      = 1'b1;
        table_r_address0 = addr_of(ip1, j_q, TBL_N);
        table_r_address1 = addr_of(ip1, jm1, TBL_N);
        state_d          = ST_CMB;
      end
      ST_CMB: state_d = (j_q == ip1) ? ST_WR : ST_KRD;
      ST_KRD: begin
        table_r_ce0      = 1'b1;
        table_r_ce1      = 1'b1;
        table_r_address0 = addr_of(i_q, k_q, TBL_N);
        table_r_address1 = addr_of(kp1, j_q, TBL_N);
        state_d          = ST_KACC;
      end
      ST_KACC: state_d = (kp1 < j_q) ? ST_KRD : ST_WR;
      ST_WR: begin
        table_r_ce0      = 1'b1;
        table_r_we0      = 1'b1;
        table_r_address0 = addr_of(i_q, j_q, TBL_N);
        table_r_d0       = v_q;
        state_d          = ST_NXT;
      end
      ST_NXT: begin
        if (j_q == idx_t'(TBL_N - 1) && i_q == '0) state_d = ST_FIN;
        else                                       state_d = ST_LD0;
      end
      ST_FIN: begin
        ap_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ap_idle  = (state_q == ST_IDLE);
  assign ap_ready = ap_done;

`ifdef NUSSINOV_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cyc_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (ap_start) cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_nussinov_core.sv
// tb_nussinov_core: randomized runs against a behavioural DP model; RAM writes are checked
// in order by a scoreboard, final tables and handshake behaviour by the main sequence.
module tb_nussinov_core;
  import nussinov_pkg::*;

  localparam int TN     = 24;
  localparam int CELLS  = TN * TN;
  localparam int PAIRS  = TN * (TN - 1) / 2;
  localparam int BUDGET = 20000;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic                ap_clk;
  logic                ap_rst_n;
  logic                ap_start;
  logic                ap_done, ap_idle, ap_ready;
  logic [ADDR_WID-1:0] addr0, addr1;
  logic                ce0, we0, ce1, we1;
  logic [DATA_WID-1:0] d0, d1, q0, q1;
`ifdef NUSSINOV_CYCLE_CNT_EN
  logic [31:0]         cycle_count;
`endif

  int   total, bad, wr_cnt, exp_cycles;
  int   init_img [CELLS];
  int   mem      [CELLS];
  int   gold     [TN][TN];
  wr_t  exp_q [$];
  logic load_req;
  logic done_prev;

  nussinov_core #(.TBL_N(TN)) dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .table_r_address0 (addr0),
    .table_r_ce0      (ce0),
    .table_r_we0      (we0),
    .table_r_d0       (d0),
    .table_r_q0       (q0),
    .table_r_address1 (addr1),
    .table_r_ce1      (ce1),
    .table_r_we1      (we1),
    .table_r_d1       (d1),
    .table_r_q1       (q1)
`ifdef NUSSINOV_CYCLE_CNT_EN
    ,
    .cycle_count      (cycle_count)
`endif
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // RAM model: one-cycle read latency, garbage on q when no read was issued.
  always @(posedge ap_clk) begin
    if (load_req)
      for (int m = 0; m < CELLS; m++) mem[m] <= init_img[m];
    if (ce0 && we0 && int'(addr0) < CELLS) mem[addr0] <= d0;
    if (ce0 && !we0 && int'(addr0) < CELLS) q0 <= mem[addr0];
    else                                     q0 <= $urandom();
    if (ce1 && !we1 && int'(addr1) < CELLS) q1 <= mem[addr1];
    else                                     q1 <= $urandom();
  end

  // Scoreboard monitor
  always @(negedge ap_clk) begin
    wr_t e;
    if (ce0 && we0) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%0d with no write expected", addr0, $signed(d0));
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", longint'(addr0), e.addr);
        chk("wr_data", $signed(d0), e.data);
      end
      if (ce1 && addr1 == addr0) chk("rw_same_addr", 1, 0);
    end
    if (we1) chk("port1_write", we1, 0);
    if (ap_done) begin
      chk("ready_eq_done", ap_ready, 1);
      if (done_prev) chk("done_width", 2, 1);
    end
    done_prev = ap_done;
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference DP straight from the recurrence, on plain 32-bit ints (wrapping sums).
  task automatic build_model(input bit from_img);
    int v, bonus;
    if (from_img)
      for (int r = 0; r < TN; r++)
        for (int c = 0; c < TN; c++) gold[r][c] = init_img[r*TN + c];
    exp_cycles = 1;
    for (int i = TN - 1; i >= 0; i--)
      for (int j = i + 1; j < TN; j++) begin
        v = imax(imax(gold[i][j], gold[i][j-1]), gold[i+1][j]);
        bonus = (i < j - 1 && ((i + 1) % 4) + ((j + 1) % 4) == 3) ? 1 : 0;
        v = imax(v, gold[i+1][j-1] + bonus);
        for (int k = i + 1; k < j; k++) v = imax(v, gold[i][k] + gold[k+1][j]);
        gold[i][j] = v;
        exp_q.push_back('{i*TN + j, v});
        exp_cycles += 5 + 2 * (j - i - 1);
      end
  endtask

  task automatic fill(input int kind);
    int r, c;
    for (int m = 0; m < CELLS; m++) begin
      r = m / TN;
      c = m % TN;
      case (kind)
        0: init_img[m] = 0;
        1: init_img[m] = (r == 10 && c == 20) ? 100 : 0;
        2: init_img[m] = (r == c) ? 0 : -5;
        3: init_img[m] = int'($urandom_range(0, 60)) - 30;
        default: init_img[m] = int'($urandom());
      endcase
    end
  endtask

  task automatic load_ram();
    @(negedge ap_clk) load_req = 1'b1;
    @(negedge ap_clk) load_req = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (ap_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge ap_clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_done: got no ap_done required within %0d cycles", nm, BUDGET);
    end
  endtask

  task automatic compare_table(input string nm);
    int mism, fr, fc;
    mism = 0;
    fr = -1;
    fc = -1;
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TN; c++)
        if (mem[r*TN + c] != gold[r][c]) begin
          if (mism == 0) begin
            fr = r;
            fc = c;
          end
          mism++;
        end
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL %s_table: %0d cells differ, first T[%0d][%0d] got %0d required %0d",
               nm, mism, fr, fc, mem[fr*TN + fc], gold[fr][fc]);
    end
  endtask

  task automatic finish_checks(input string nm, input int runs);
    chk({nm, "_writes"}, wr_cnt, runs * PAIRS);
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_idle"}, ap_idle, 1);
    compare_table(nm);
`ifdef NUSSINOV_CYCLE_CNT_EN
    chk({nm, "_cycles"}, cycle_count, exp_cycles);
`endif
  endtask

  task automatic run_one(input string nm);
    load_ram();
    build_model(1'b1);
    wr_cnt = 0;
    repeat ($urandom_range(0, 3)) @(negedge ap_clk);
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    chk({nm, "_busy"}, ap_idle, 0);
    wait_done(nm);
    @(negedge ap_clk);
    finish_checks(nm, 1);
  endtask

  initial begin
    int lo;
    bit hit;
    total     = 0;
    bad       = 0;
    wr_cnt    = 0;
    done_prev = 1'b0;
    ap_rst_n  = 1'b0;
    ap_start  = 1'b0;
    load_req  = 1'b0;
    repeat (3) @(negedge ap_clk);

    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_ce0", ce0, 0);
    chk("rst_we0", we0, 0);
    chk("rst_ce1", ce1, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_d0", d0, 0);
`ifdef NUSSINOV_CYCLE_CNT_EN
    chk("rst_cycles", cycle_count, 0);
`endif
    ap_rst_n = 1'b1;

    fill(0);
    run_one("zero");
    chk("zero_corner", mem[(TN-2)*TN + TN - 1], 0);
    chk("zero_t0_5_pos", (mem[0*TN + 5] >= 1) ? 1 : 0, 1);
    chk("zero_t2_7_pos", (mem[2*TN + 7] >= 1) ? 1 : 0, 1);

    fill(1);
    run_one("preset100");
    lo = 0;
    for (int r = 0; r <= 10; r++)
      for (int c = 20; c < TN; c++)
        if (mem[r*TN + c] < 100) lo++;
    chk("preset100_region_low_cells", lo, 0);

    fill(2);
    run_one("neg5");
    fill(3);
    run_one("rand_small");
    fill(4);
    run_one("rand_wide");

    // Asynchronous reset in the middle of a run
    fill(3);
    load_ram();
    build_model(1'b1);
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge ap_clk);
      if (c >= 150 && ce0) begin
        hit = 1'b1;
        break;
      end
    end
    chk("midrst_found_access", hit, 1);
    #1 ap_rst_n = 1'b0;
    #1;
    chk("midrst_ce0", ce0, 0);
    chk("midrst_ce1", ce1, 0);
    chk("midrst_we0", we0, 0);
    chk("midrst_idle", ap_idle, 1);
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      chk("midrst_hold_ce0", ce0, 0);
      chk("midrst_hold_ce1", ce1, 0);
    end
    ap_rst_n = 1'b1;
    fill(0);
    run_one("after_rst");

    // ap_start held high: back-to-back runs over the evolving table
    fill(3);
    load_ram();
    build_model(1'b1);
    build_model(1'b0);
    wr_cnt = 0;
    ap_start = 1'b1;
    wait_done("held_first");
    @(negedge ap_clk);
    chk("held_idle_gap", ap_idle, 1);
    @(negedge ap_clk);
    chk("held_restart", ap_idle, 0);
    ap_start = 1'b0;
    wait_done("held_second");
    @(negedge ap_clk);
    finish_checks("held", 2);
    repeat (3) @(negedge ap_clk);
    chk("held_stays_idle", ap_idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
